multiword_add_seq: RTL

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

---
 rtl/multiword_add_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/multiword_add_seq.sv
// Multi-word adder/subtractor that reuses one 16-bit adder slice over NSLICE cycles.
// It has a start/in_ready request handshake and an out_valid/out_ready result handshake.
module multiword_add_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow,
    output logic             busy
);

    localparam int NSLICE = WIDTH / 16;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [KW-1:0]    k;

    logic [KW+3:0]    base;
    logic [15:0]      a_slice;
    logic [15:0]      b_slice;
    logic [16:0]      slice_sum;
    logic [15:0]      s;
    logic             c;
    logic             last;
    logic             accept;

    // The single shared 16-bit slice adder; the slice is selected by k.
    assign base      = {k, 4'b0000};
    assign a_slice   = a_reg[base +: 16];
    assign b_slice   = b_reg[base +: 16];
    assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {16'd0, carry};
    assign s         = slice_sum[15:0];
    assign c         = slice_sum[16];
    assign last      = (k == K_LAST);
    assign accept    = start && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (last) state_next = DONE;
            DONE: if (out_ready) state_next = DONE == state ? IDLE : state;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            RUN:  busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtraction is A + ~B + 1: the +1 enters through the initial carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            k        <= '0;
            Result   <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept) begin
            a_reg <= operand1;
            b_reg <= sub ? ~operand2 : operand2;
            carry <= sub;
            k     <= '0;
        end else if (state == RUN) begin
            Result[base +: 16] <= s;
            carry              <= c;
            if (last) begin
                k        <= '0;
                Cout     <= c;
                Overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (s[15] != a_reg[WIDTH-1]);
            end else begin
                k <= k + 1'b1;
            end
        end
    end

endmodule
